// File: rtl/t03_rf_pkg.sv
// Shared constants and helpers for the t03 multi-port integer register file.
package t03_rf_pkg;

    localparam int unsigned RfXlen    = 32;
    localparam int unsigned RfNumRegs = 32;

    // Address width for a register count; never narrower than one bit.
    function automatic int unsigned rf_aw(int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/t03_rf_scoreboard.sv
// Pending-load scoreboard: one pending bit per nonzero register plus a
// registered count of outstanding loads.
module t03_rf_scoreboard
    import t03_rf_pkg::*;
#(
    parameter int unsigned NUM_REGS = RfNumRegs,
    parameter int unsigned AW       = rf_aw(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pend_set_i,
    input  logic [AW-1:0]       pend_addr_i,
    input  logic                clr_en_i,
    input  logic [AW-1:0]       clr_addr_i,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [AW:0]         pend_cnt_o
);

    localparam int unsigned CW = AW + 1;

    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [NUM_REGS-1:0] rise, fall;
    logic [CW-1:0]       cnt_q, cnt_d;

    // A set and a clear of the same register in one cycle leaves it pending,
    // since the set represents a newly issued load.
    always_comb begin
        pend_d    = '0;
        pend_d[0] = 1'b0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            pend_d[r] = (pend_set_i && (pend_addr_i == AW'(r))) ||
                        (pend_q[r] && !(clr_en_i && (clr_addr_i == AW'(r))));
        end
        rise  = pend_d & ~pend_q;
        fall  = pend_q & ~pend_d;
        // At most one set and one clear per cycle, so each side moves the count by one.
        cnt_d = cnt_q + CW'(|rise) - CW'(|fall);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_o  = pend_q;
    assign pend_cnt_o = cnt_q;

    a_cnt_matches_bits : assert property (
        @(posedge clk) disable iff (reset) cnt_q == CW'($countones(pend_q))
    );

endmodule

// File: rtl/t03_regfile_mp.sv
// Multi-port integer register file: NUM_RD read ports, ALU (A) and load-return (B)
// write ports, optional write-to-read bypass and a pending-load scoreboard.
module t03_regfile_mp
    import t03_rf_pkg::*;
#(
    parameter int unsigned XLEN     = RfXlen,
    parameter int unsigned NUM_REGS = RfNumRegs,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = rf_aw(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    input  logic                   wa_en_i,
    input  logic [AW-1:0]          wa_addr_i,
    input  logic [XLEN-1:0]        wa_data_i,
    input  logic                   wb_en_i,
    input  logic [AW-1:0]          wb_addr_i,
    input  logic [XLEN-1:0]        wb_data_i,
    input  logic                   pend_set_i,
    input  logic [AW-1:0]          pend_addr_i,
    output logic [AW:0]            pend_cnt_o,
    output logic                   waw_err_o
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic                wa_hit, wb_hit;
    logic                waw_q, waw_d;
    logic [NUM_REGS-1:0] pending;

    // Port A wins a same-address collision; B's data is dropped for that cycle.
    always_comb begin
        wa_hit = wa_en_i && (wa_addr_i != '0);
        waw_d  = wa_hit && wb_en_i && (wb_addr_i == wa_addr_i);
        wb_hit = wb_en_i && (wb_addr_i != '0) && !waw_d;
        regs_d = regs_q;
        if (wb_hit) begin
            regs_d[wb_addr_i] = wb_data_i;
        end
        if (wa_hit) begin
            regs_d[wa_addr_i] = wa_data_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            waw_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            waw_q  <= waw_d;
        end
    end

    assign waw_err_o = waw_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rdata;

        assign addr = rd_addr_i[i*AW +: AW];

        always_comb begin
            rdata = regs_q[addr];
            if (addr == '0) begin
                rdata = '0;
            end else if ((BYPASS != 0) && wa_en_i && (wa_addr_i == addr)) begin
                rdata = wa_data_i;
            end else if ((BYPASS != 0) && wb_en_i && (wb_addr_i == addr)) begin
                rdata = wb_data_i;
            end
        end

        assign rd_data_o[i*XLEN +: XLEN] = rdata;
        // No bypass of a same-cycle clear: keeps decode's stall path short.
        assign rd_busy_o[i] = pending[addr];
    end

    t03_rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .pend_set_i  (pend_set_i),
        .pend_addr_i (pend_addr_i),
        .clr_en_i    (wb_en_i),
        .clr_addr_i  (wb_addr_i),
        .pending_o   (pending),
        .pend_cnt_o  (pend_cnt_o)
    );

endmodule
